// File: rtl/ext_gate_ctrl_if.sv
// ----------------------------------------------------------------------------
// ext_gate_ctrl_if
//   Bundles the trigger, strobe, configuration and status signals of the
//   receive-gate sequencer. All signals live in the rxclk domain, except
//   ext_trig, which may be asynchronous when the sequencer is built with
//   EXT_GATE_TRIG_SYNC_EN.
//
//   enable        arm the sequencer; low aborts any window
//   ext_trig      external trigger level; a rising edge starts a sequence
//   rxstrobe      decimated sample strobe, one rxclk wide
//   delay         trigger-to-align delay in rxclk cycles
//   width         window length in rxstrobe samples; 0 disables triggering
//   clear_status  clears missed
//   gate_enable   window active, drives the receive buffer gate
//   busy          sequencer not idle
//   missed        sticky: a trigger edge arrived while busy
//   win_count     completed windows, wraps
//
//   master : the side that drives configuration and observes status
//   slave  : the sequencer
// ----------------------------------------------------------------------------
interface ext_gate_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             ext_trig;
  logic             rxstrobe;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] width;
  logic             clear_status;
  logic             gate_enable;
  logic             busy;
  logic             missed;
  logic [CNT_W-1:0] win_count;

  modport master (
    output enable, ext_trig, rxstrobe, delay, width, clear_status,
    input  gate_enable, busy, missed, win_count
  );

  modport slave (
    input  enable, ext_trig, rxstrobe, delay, width, clear_status,
    output gate_enable, busy, missed, win_count
  );
endinterface

// File: rtl/ext_gate_ctrl.sv
// ----------------------------------------------------------------------------
// ext_gate_ctrl
//   Receive-gate sequencer. It turns an external trigger edge into an
//   acquisition window aligned to the decimated sample strobe:
//     trigger edge -> programmable delay (rxclk cycles) -> wait for the next
//     rxstrobe -> gate_enable high for exactly 'width' strobes.
//   Window count and a sticky missed-trigger flag are reported.
//
//   Ports
//     rxclk    receive sample clock, sole clock
//     reset_n  asynchronous active-low reset
//     bus      ext_gate_ctrl_if.slave (trigger, strobe, config, status)
//
//   Build option
//     EXT_GATE_TRIG_SYNC_EN  when defined, ext_trig passes through a two-flop
//                            synchronizer ahead of edge detection; otherwise it
//                            is taken to be synchronous to rxclk.
// ----------------------------------------------------------------------------
module ext_gate_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic            rxclk,
  input  logic            reset_n,
  ext_gate_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ALIGN = 2'd2,
    GATE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             trig, trig_q, trig_edge;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] wlat_q, wlat_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             missed_q, missed_d;
  logic             gate_q;

  // --------------------------------------------------------------------------
  // Trigger conditioning and edge detect
  // --------------------------------------------------------------------------
`ifdef EXT_GATE_TRIG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], bus.ext_trig};
  end

  assign trig = sync_q[1];
`else
  assign trig = bus.ext_trig;
`endif

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) trig_q <= 1'b0;
    else          trig_q <= trig;
  end

  assign trig_edge = trig & ~trig_q;

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dcnt_q   <= '0;
      scnt_q   <= '0;
      wlat_q   <= '0;
      win_q    <= '0;
      missed_q <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      scnt_q   <= scnt_d;
      wlat_q   <= wlat_d;
      win_q    <= win_d;
      missed_q <= missed_d;
      // Registered copy of "next state is GATE" so the gate is glitch-free
      // and high exactly for the cycles the FSM sits in GATE.
      gate_q   <= (state_d == GATE);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    scnt_d   = scnt_q;
    wlat_d   = wlat_q;
    win_d    = win_q;
    missed_d = missed_q;

    case (state_q)
      IDLE: begin
        if (bus.enable && trig_edge && (bus.width != '0)) begin
          // The first DELAY cycle counts as one of the 'delay' cycles, so
          // delay=d reaches ALIGN d cycles after entering DELAY; delay=0
          // still spends a single cycle in DELAY.
          dcnt_d  = (bus.delay == '0) ? '0 : (bus.delay - ONE);
          wlat_d  = bus.width;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (dcnt_q == '0) state_d = ALIGN;
        else              dcnt_d  = dcnt_q - ONE;
      end
      ALIGN: begin
        // Only strobes sampled while already in ALIGN can align the window.
        if (bus.rxstrobe) begin
          scnt_d  = wlat_q;
          state_d = GATE;
        end
      end
      GATE: begin
        if (bus.rxstrobe) begin
          if (scnt_q == ONE) begin
            state_d = IDLE;
            win_d   = win_q + ONE;
          end else begin
            scnt_d  = scnt_q - ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disarming aborts whatever is in flight without counting a window.
    if (!bus.enable) begin
      state_d = IDLE;
      win_d   = win_q;
    end

    // Set has priority over clear so a coincident miss is never lost.
    if (trig_edge && (bus.width != '0) && (state_q != IDLE))
      missed_d = 1'b1;
    else if (bus.clear_status)
      missed_d = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.gate_enable = gate_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.missed      = missed_q;
  assign bus.win_count   = win_q;

endmodule

// File: tb/tb_ext_gate_ctrl.sv
module tb_ext_gate_ctrl;
`ifdef EXT_GATE_TRIG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int PER = 100;

  logic rxclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 rxclk = ~rxclk;

  ext_gate_ctrl_if #(.CNT_W(16)) bus();
  ext_gate_ctrl_if #(.CNT_W(4))  b4();

  ext_gate_ctrl #(.CNT_W(16)) dut  (.rxclk(rxclk), .reset_n(reset_n), .bus(bus));
  ext_gate_ctrl #(.CNT_W(4))  dut4 (.rxclk(rxclk), .reset_n(reset_n), .bus(b4));

  // free-running strobe, one cycle every PER
  int ph = 0;
  int cyc = 0;
  always @(posedge rxclk) begin
    ph  <= (ph == PER-1) ? 0 : ph + 1;
    cyc <= cyc + 1;
  end
  assign bus.rxstrobe = (ph == 0);
  assign b4.rxstrobe  = (ph == 0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard: one entry per expected window (full or aborted)
  typedef struct {
    int          strobes;
    int          len;
    int          rise;
    logic [15:0] win;
  } exp_t;
  exp_t sbq[$];
  exp_t me;

  logic gp = 1'b0;
  int glen = 0, gstb = 0, grise = 0;
  always @(negedge rxclk) begin
    if (bus.gate_enable && !gp) begin glen = 0; gstb = 0; grise = cyc; end
    if (bus.gate_enable) begin
      glen++;
      if (bus.rxstrobe) gstb++;
    end
    if (!bus.gate_enable && gp) begin
      if (sbq.size() == 0) chk("unexpected_window", 32'd1, 32'd0);
      else begin
        me = sbq.pop_front();
        chk("win_strobes", gstb, me.strobes);
        if (me.len >= 0)  chk("win_len", glen, me.len);
        if (me.rise >= 0) chk("win_rise", grise, me.rise);
        chk("win_count_at_close", bus.win_count, me.win);
      end
    end
    gp = bus.gate_enable;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge rxclk); #1; end
  endtask

  task automatic wait_ph(input int target);
    int g = 0;
    while (ph != target && g < PER + 2) begin tick(); g++; end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (bus.busy && n < max) begin tick(); n++; end
    chk({tag, "_idle"}, bus.busy, 32'd0);
  endtask

  task automatic wait_gate(input string tag, input int max);
    int n = 0;
    while (!bus.gate_enable && n < max) begin tick(); n++; end
    chk({tag, "_gate_up"}, bus.gate_enable, 32'd1);
  endtask

  // trigger just driven this cycle: the watched flag must stay low for LAT
  // cycles and be high on the LAT-th cycle after the drive
  task automatic edge_lat(input string tag, input bit sel_missed);
    for (int i = 0; i < LAT; i++) begin
      @(negedge rxclk);
      chk({tag, "_pre"}, sel_missed ? bus.missed : bus.busy, 32'd0);
      tick();
    end
    @(negedge rxclk);
    chk({tag, "_at"}, sel_missed ? bus.missed : bus.busy, 32'd1);
  endtask

  task automatic push(input int s, input int l, input int r, input int w);
    exp_t e;
    e.strobes = s; e.len = l; e.rise = r; e.win = 16'(w);
    sbq.push_back(e);
  endtask

  initial begin
    int c, n, g;
    logic seen;
    bus.enable = 0; bus.ext_trig = 0; bus.delay = '0; bus.width = '0; bus.clear_status = 0;
    b4.enable = 0;  b4.ext_trig = 0;  b4.delay = '0;  b4.width = '0;  b4.clear_status = 0;
    #2;
    chk("rst_gate", bus.gate_enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_missed", bus.missed, 0);
    chk("rst_win", bus.win_count, 0);
    @(posedge rxclk); #1;
    reset_n = 1;
    tick(2);
    bus.enable = 1;

    // 1: delay=10 width=4; a strobe lands in the last DELAY cycle (ignored)
    bus.delay = 16'd10; bus.width = 16'd4;
    wait_ph(PER - LAT - 9);
    c = cyc;
    bus.ext_trig = 1;
    push(4, 4*PER, c + LAT + 110, 1);
    edge_lat("t1_trig_latency", 1'b0);
    bus.delay = 16'd1000; bus.width = 16'd1;   // must not affect the window in flight
    tick(3);
    bus.ext_trig = 0;
    wait_idle("t1", 800);
    chk("t1_win", bus.win_count, 1);

    // 2: delay=0 width=1, trigger edge coincident with a strobe
    bus.delay = 16'd0; bus.width = 16'd1;
    tick(4);
    wait_ph((PER - (LAT - 1)) % PER);
    c = cyc;
    bus.ext_trig = 1;
    push(1, PER, c + LAT - 1 + 101, 2);
    tick(5);
    bus.ext_trig = 0;
    wait_idle("t2", 400);

    // 3: trigger during GATE sets missed, no extra window; clear; set wins over clear
    bus.width = 16'd2;
    bus.ext_trig = 1;
    push(2, 2*PER, -1, 3);
    tick(5);
    bus.ext_trig = 0;
    wait_gate("t3", 300);
    tick(3);
    bus.ext_trig = 1;
    edge_lat("t3_missed_latency", 1'b1);
    tick(3);
    bus.ext_trig = 0;
    wait_idle("t3", 400);
    chk("t3_missed_sticky", bus.missed, 1);
    chk("t3_win_once", bus.win_count, 3);
    bus.clear_status = 1; tick(); bus.clear_status = 0;
    @(negedge rxclk);
    chk("t3_cleared", bus.missed, 0);
    bus.ext_trig = 1;
    push(2, 2*PER, -1, 4);
    tick(5);
    bus.ext_trig = 0;
    tick(3);
    bus.ext_trig = 1;
    tick(LAT - 1);
    bus.clear_status = 1; tick(); bus.clear_status = 0;
    @(negedge rxclk);
    chk("t3_set_beats_clear", bus.missed, 1);
    tick(3);
    bus.ext_trig = 0;
    wait_idle("t3b", 400);
    bus.clear_status = 1; tick(); bus.clear_status = 0;

    // 4: enable dropped after 2 of 8 gate strobes, then a full 8-strobe window
    bus.width = 16'd8;
    bus.ext_trig = 1;
    push(2, -1, -1, 4);
    tick(5);
    bus.ext_trig = 0;
    n = 0; g = 0;
    while (n < 2 && g < 1000) begin
      @(negedge rxclk);
      if (bus.gate_enable && bus.rxstrobe) n++;
      tick(); g++;
    end
    chk("t4_strobes_seen", n, 2);
    bus.enable = 0;
    tick();
    @(negedge rxclk);
    chk("t4_abort_gate", bus.gate_enable, 0);
    chk("t4_abort_busy", bus.busy, 0);
    chk("t4_abort_win", bus.win_count, 4);
    bus.enable = 1;
    tick(2);
    bus.ext_trig = 1;
    push(8, 8*PER, -1, 5);
    tick(5);
    bus.ext_trig = 0;
    wait_idle("t4", 1200);

    // 5: width=0 triggers are ignored; width change while busy cannot set missed
    bus.width = 16'd0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      bus.ext_trig = 1;
      for (int j = 0; j < 6; j++) begin @(negedge rxclk); seen |= bus.busy; tick(); end
      bus.ext_trig = 0;
      for (int j = 0; j < 6; j++) begin @(negedge rxclk); seen |= bus.busy; tick(); end
    end
    chk("t5_no_busy", seen, 0);
    chk("t5_no_missed", bus.missed, 0);
    bus.width = 16'd2;
    bus.ext_trig = 1;
    push(2, 2*PER, -1, 6);
    tick(5);
    bus.ext_trig = 0;
    bus.width = 16'd0;
    tick(5);
    bus.ext_trig = 1;
    tick(LAT + 3);
    bus.ext_trig = 0;
    chk("t5_busy_zero_w_miss", bus.missed, 0);
    wait_idle("t5", 400);

    // 6: async reset mid-DELAY and mid-GATE, then a normal sequence
    bus.delay = 16'd50; bus.width = 16'd2;
    bus.ext_trig = 1; tick(5); bus.ext_trig = 0; tick(3);
    bus.ext_trig = 1; tick(LAT + 2);
    chk("t6_delay_busy", bus.busy, 1);
    chk("t6_delay_missed", bus.missed, 1);
    bus.ext_trig = 0;
    #2 reset_n = 0;
    #1;
    chk("t6a_gate", bus.gate_enable, 0);
    chk("t6a_busy", bus.busy, 0);
    chk("t6a_missed", bus.missed, 0);
    chk("t6a_win", bus.win_count, 0);
    tick(); reset_n = 1; tick(2);
    bus.delay = 16'd0;
    bus.ext_trig = 1;
    push(0, -1, -1, 0);
    tick(5);
    bus.ext_trig = 0;
    wait_gate("t6b", 300);
    tick();
    #2 reset_n = 0;
    #1;
    chk("t6b_gate", bus.gate_enable, 0);
    chk("t6b_busy", bus.busy, 0);
    chk("t6b_win", bus.win_count, 0);
    tick(); reset_n = 1; tick(2);
    bus.ext_trig = 1;
    push(2, 2*PER, -1, 1);
    edge_lat("t6_post_reset_latency", 1'b0);
    tick(3);
    bus.ext_trig = 0;
    wait_idle("t6c", 400);
    chk("t6_post_win", bus.win_count, 1);

    // 7: win_count wrap on a 4-bit instance
    b4.enable = 1; b4.delay = 4'd0; b4.width = 4'd1;
    for (int i = 1; i <= 16; i++) begin
      b4.ext_trig = 1;
      tick(LAT + 3);
      b4.ext_trig = 0;
      g = 0;
      while (b4.busy && g < 300) begin tick(); g++; end
      tick(2);
      chk($sformatf("t7_wrap_%0d", i), b4.win_count, 32'(i % 16));
    end

    tick(4);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
